game_ctrl: RTL and testbench

GAME_CTRL -- requirements
Module: game_ctrl

---
 rtl/game_pkg.sv | 35 +++
 rtl/win_detect.sv | 20 ++
 rtl/game_ctrl.sv | 177 +++++++++++++++++
 tb/tb_game_ctrl.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared definitions for the tic-tac-toe controller: cell codes, FSM encoding
// and the table of cell indices that make up each of the eight lines.
package game_pkg;

  localparam int unsigned NUM_CELLS = 9;
  localparam int unsigned NUM_LINES = 8;
  localparam int unsigned CELL_W    = 2;
  localparam int unsigned IDX_W     = 4;
  localparam int unsigned CNT_W     = 4;
  localparam int unsigned BOARD_W   = NUM_CELLS * CELL_W;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    P1    = 2'b01,
    P2    = 2'b10
  } cell_t;

  typedef enum logic [2:0] {
    P1_TURN = 3'd0,
    P2_TURN = 3'd1,
    CHECK   = 3'd2,
    WIN     = 3'd3,
    DRAW    = 3'd4
  } state_t;

  typedef logic [NUM_CELLS-1:0][CELL_W-1:0] board_t;

  // Rows 0-2, columns 3-5, main diagonal 6, anti-diagonal 7.
  localparam int unsigned LINE_CELLS [NUM_LINES][3] = '{
    '{0, 1, 2}, '{3, 4, 5}, '{6, 7, 8},
    '{0, 3, 6}, '{1, 4, 7}, '{2, 5, 8},
    '{0, 4, 8}, '{2, 4, 6}
  };

endpackage

// File: rtl/win_detect.sv
// Combinational line detector: flags every line fully owned by the given player.
module win_detect
  import game_pkg::*;
(
  input  logic [BOARD_W-1:0]   cells,
  input  logic [CELL_W-1:0]    player,
  output logic [NUM_LINES-1:0] lines
);

  logic real_player;
  assign real_player = (player != EMPTY);

  for (genvar l = 0; l < NUM_LINES; l++) begin : g_line
    assign lines[l] = real_player
                    && (cells[CELL_W*LINE_CELLS[l][0] +: CELL_W] == player)
                    && (cells[CELL_W*LINE_CELLS[l][1] +: CELL_W] == player)
                    && (cells[CELL_W*LINE_CELLS[l][2] +: CELL_W] == player);
  end

endmodule

// File: rtl/game_ctrl.sv
// Two-player tic-tac-toe controller: arbitrates move requests, owns the board,
// and reports turn, ack/nack pulses, winner and completed lines.
module game_ctrl
  import game_pkg::*;
#(
  parameter int unsigned FIRST_PLAYER = 1
) (
  input  logic        clk50M,
  input  logic        reset_n,
  input  logic        p1_req,
  input  logic [3:0]  p1_idx,
  input  logic        p2_req,
  input  logic [3:0]  p2_idx,
  input  logic        restart,
  output logic [1:0]  position_1,
  output logic [1:0]  position_2,
  output logic [1:0]  position_3,
  output logic [1:0]  position_4,
  output logic [1:0]  position_5,
  output logic [1:0]  position_6,
  output logic [1:0]  position_7,
  output logic [1:0]  position_8,
  output logic [1:0]  position_9,
  output logic [1:0]  turn,
  output logic        move_ack,
  output logic        move_nack,
  output logic [1:0]  winner,
  output logic        game_over,
  output logic [7:0]  win_line
);

  localparam state_t FIRST_STATE = (FIRST_PLAYER == 2) ? P2_TURN : P1_TURN;
  localparam cell_t  FIRST_CODE  = (FIRST_PLAYER == 2) ? P2 : P1;

  state_t               state_q, state_d;
  board_t               board_q, board_d;
  logic [CNT_W-1:0]     count_q, count_d;
  cell_t                mover_q, mover_d;
  cell_t                winner_q, winner_d;
  logic [NUM_LINES-1:0] win_line_q, win_line_d;
  logic                 ack_q, ack_d;
  logic                 nack_q, nack_d;
  logic [1:0]           turn_q, turn_d;
  logic                 over_q, over_d;
  logic                 p1_held_q, p2_held_q;

  // A request counts only on the cycle it rises; holding it does not repeat it.
  logic p1_new, p2_new;
  assign p1_new = p1_req & ~p1_held_q;
  assign p2_new = p2_req & ~p2_held_q;

  logic             in_p2;
  logic             hold_new, other_new, hold_ok;
  logic [IDX_W-1:0] hold_idx;
  cell_t            hold_code;
  assign in_p2     = (state_q == P2_TURN);
  assign hold_new  = in_p2 ? p2_new : p1_new;
  assign other_new = in_p2 ? p1_new : p2_new;
  assign hold_idx  = in_p2 ? p2_idx : p1_idx;
  assign hold_code = in_p2 ? P2 : P1;
  assign hold_ok   = (hold_idx <= IDX_W'(NUM_CELLS - 1)) && (board_q[hold_idx] == EMPTY);

  logic [NUM_LINES-1:0] line_mask;

  win_detect u_win_detect (
    .cells  (board_q),
    .player (mover_q),
    .lines  (line_mask)
  );

  // Next-state, board update and pulse generation.
  always_comb begin
    state_d    = state_q;
    board_d    = board_q;
    count_d    = count_q;
    mover_d    = mover_q;
    winner_d   = winner_q;
    win_line_d = win_line_q;
    ack_d      = 1'b0;
    nack_d     = 1'b0;

    if (restart) begin
      state_d    = FIRST_STATE;
      board_d    = '0;
      count_d    = '0;
      winner_d   = EMPTY;
      win_line_d = '0;
    end else begin
      case (state_q)
        P1_TURN, P2_TURN: begin
          if (hold_new) begin
            if (hold_ok) begin
              board_d[hold_idx] = hold_code;
              count_d           = count_q + CNT_W'(1);
              mover_d           = hold_code;
              ack_d             = 1'b1;
              state_d           = CHECK;
            end else begin
              nack_d = 1'b1;
            end
          end
          if (other_new) nack_d = 1'b1;
        end
        CHECK: begin
          // A line on the ninth move still wins, so lines are tested before the draw.
          if (|line_mask) begin
            state_d    = WIN;
            winner_d   = mover_q;
            win_line_d = line_mask;
          end else if (count_q == CNT_W'(NUM_CELLS)) begin
            state_d = DRAW;
          end else begin
            state_d = (mover_q == P1) ? P2_TURN : P1_TURN;
          end
          nack_d = p1_new | p2_new;
        end
        WIN, DRAW: nack_d = p1_new | p2_new;
        default:   state_d = FIRST_STATE;
      endcase
    end

    // Nobody may move during CHECK, so turn shows 00 there as well as after the game.
    case (state_d)
      P1_TURN: turn_d = P1;
      P2_TURN: turn_d = P2;
      default: turn_d = EMPTY;
    endcase
    over_d = (state_d == WIN) || (state_d == DRAW);
  end

  always_ff @(posedge clk50M or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= FIRST_STATE;
      board_q    <= '0;
      count_q    <= '0;
      mover_q    <= FIRST_CODE;
      winner_q   <= EMPTY;
      win_line_q <= '0;
      ack_q      <= 1'b0;
      nack_q     <= 1'b0;
      turn_q     <= FIRST_CODE;
      over_q     <= 1'b0;
      p1_held_q  <= 1'b0;
      p2_held_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      board_q    <= board_d;
      count_q    <= count_d;
      mover_q    <= mover_d;
      winner_q   <= winner_d;
      win_line_q <= win_line_d;
      ack_q      <= ack_d;
      nack_q     <= nack_d;
      turn_q     <= turn_d;
      over_q     <= over_d;
      p1_held_q  <= p1_req;
      p2_held_q  <= p2_req;
    end
  end

  assign position_1 = board_q[0];
  assign position_2 = board_q[1];
  assign position_3 = board_q[2];
  assign position_4 = board_q[3];
  assign position_5 = board_q[4];
  assign position_6 = board_q[5];
  assign position_7 = board_q[6];
  assign position_8 = board_q[7];
  assign position_9 = board_q[8];
  assign turn       = turn_q;
  assign move_ack   = ack_q;
  assign move_nack  = nack_q;
  assign winner     = winner_q;
  assign game_over  = over_q;
  assign win_line   = win_line_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Directed bench for game_ctrl: per-cycle vector table plus hand-written
// sequences for ninth-move win and asynchronous reset during CHECK.
module tb_game_ctrl;

  logic       clk50M = 1'b0;
  logic       reset_n;
  logic       p1_req, p2_req, restart;
  logic [3:0] p1_idx, p2_idx;
  logic [1:0] position_1, position_2, position_3, position_4, position_5;
  logic [1:0] position_6, position_7, position_8, position_9;
  logic [1:0] turn, winner;
  logic       move_ack, move_nack, game_over;
  logic [7:0] win_line;

  game_ctrl #(.FIRST_PLAYER(1)) dut (
    .clk50M(clk50M), .reset_n(reset_n),
    .p1_req(p1_req), .p1_idx(p1_idx), .p2_req(p2_req), .p2_idx(p2_idx),
    .restart(restart),
    .position_1(position_1), .position_2(position_2), .position_3(position_3),
    .position_4(position_4), .position_5(position_5), .position_6(position_6),
    .position_7(position_7), .position_8(position_8), .position_9(position_9),
    .turn(turn), .move_ack(move_ack), .move_nack(move_nack),
    .winner(winner), .game_over(game_over), .win_line(win_line)
  );

  always #10 clk50M = ~clk50M;

  logic [17:0] board;
  assign board = {position_9, position_8, position_7, position_6, position_5,
                  position_4, position_3, position_2, position_1};

  logic [32:0] snap;
  assign snap = {move_ack, move_nack, turn, game_over, winner, win_line, board};

  typedef struct {
    logic p1; logic [3:0] i1; logic p2; logic [3:0] i2; logic rs;
    logic ack; logic nack; logic [1:0] turn; logic go; logic [1:0] win;
    logic [7:0] wl; logic [17:0] brd;
  } vec_t;

  vec_t vq[$];
  int   checks = 0;
  int   errors = 0;

  task automatic add(input logic p1, input logic [3:0] i1, input logic p2, input logic [3:0] i2,
                     input logic rs, input logic ack, input logic nack, input logic [1:0] tn,
                     input logic go, input logic [1:0] win, input logic [7:0] wl,
                     input logic [17:0] brd);
    vec_t v;
    v.p1 = p1; v.i1 = i1; v.p2 = p2; v.i2 = i2; v.rs = rs;
    v.ack = ack; v.nack = nack; v.turn = tn; v.go = go; v.win = win; v.wl = wl; v.brd = brd;
    vq.push_back(v);
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic cyc(input logic a, input logic [3:0] ai, input logic b, input logic [3:0] bi,
                     input logic rs);
    p1_req = a; p1_idx = ai; p2_req = b; p2_idx = bi; restart = rs;
    @(posedge clk50M);
    #1;
  endtask

  localparam logic [17:0] B0 = 18'b0;
  // Board constants are written cell 9 (left) down to cell 1 (right).
  localparam logic [17:0] A1 = 18'b00_00_00_00_01_00_00_00_00;
  localparam logic [17:0] A2 = 18'b00_00_00_00_01_10_00_00_00;
  localparam logic [17:0] BA = 18'b00_00_00_00_00_00_00_00_01;
  localparam logic [17:0] BB = 18'b00_00_00_00_00_10_00_00_01;
  localparam logic [17:0] BC = 18'b00_00_00_00_00_10_00_01_01;
  localparam logic [17:0] BD = 18'b00_00_00_00_10_10_00_01_01;
  localparam logic [17:0] BE = 18'b00_00_00_00_10_10_01_01_01;
  localparam logic [17:0] C2 = 18'b00_00_00_00_00_00_00_10_01;
  localparam logic [17:0] C3 = 18'b00_00_00_00_00_00_01_10_01;
  localparam logic [17:0] C4 = 18'b00_00_00_00_10_00_01_10_01;
  localparam logic [17:0] C5 = 18'b00_00_00_00_10_01_01_10_01;
  localparam logic [17:0] C6 = 18'b00_00_00_10_10_01_01_10_01;
  localparam logic [17:0] C7 = 18'b00_01_00_10_10_01_01_10_01;
  localparam logic [17:0] C8 = 18'b00_01_10_10_10_01_01_10_01;
  localparam logic [17:0] C9 = 18'b01_01_10_10_10_01_01_10_01;
  localparam logic [17:0] HC = 18'b00_00_00_00_00_01_00_10_01;
  localparam logic [17:0] HD = 18'b00_00_00_10_00_01_00_10_01;

  initial begin
    int moves [9];
    // p1 req/idx, p2 req/idx, restart | ack, nack, turn, game_over, winner, win_line, board
    add(1,4,0,0,0, 1,0,2'b00,0,2'b00,8'h00,A1);  // first move, ack next cycle
    add(0,0,0,0,0, 0,0,2'b10,0,2'b00,8'h00,A1);
    add(0,0,1,4,0, 0,1,2'b10,0,2'b00,8'h00,A1);  // occupied cell
    add(0,0,0,0,0, 0,0,2'b10,0,2'b00,8'h00,A1);
    add(0,0,1,9,0, 0,1,2'b10,0,2'b00,8'h00,A1);  // index out of range
    add(0,0,0,0,0, 0,0,2'b10,0,2'b00,8'h00,A1);
    add(1,0,0,0,0, 0,1,2'b10,0,2'b00,8'h00,A1);  // not p1's turn
    add(0,0,1,3,0, 1,0,2'b00,0,2'b00,8'h00,A2);
    add(0,0,0,0,0, 0,0,2'b01,0,2'b00,8'h00,A2);
    add(1,0,0,0,1, 0,0,2'b01,0,2'b00,8'h00,B0);  // restart beats move
    add(0,0,0,0,0, 0,0,2'b01,0,2'b00,8'h00,B0);
    add(1,0,1,5,0, 1,1,2'b00,0,2'b00,8'h00,BA);  // both request
    add(0,0,0,0,0, 0,0,2'b10,0,2'b00,8'h00,BA);
    add(0,0,1,3,0, 1,0,2'b00,0,2'b00,8'h00,BB);
    add(0,0,0,0,0, 0,0,2'b01,0,2'b00,8'h00,BB);
    add(1,1,0,0,0, 1,0,2'b00,0,2'b00,8'h00,BC);
    add(0,0,0,0,0, 0,0,2'b10,0,2'b00,8'h00,BC);
    add(0,0,1,4,0, 1,0,2'b00,0,2'b00,8'h00,BD);
    add(0,0,0,0,0, 0,0,2'b01,0,2'b00,8'h00,BD);
    add(1,2,0,0,0, 1,0,2'b00,0,2'b00,8'h00,BE);
    add(0,0,0,0,0, 0,0,2'b00,1,2'b01,8'h01,BE);  // top row win
    add(0,0,1,8,0, 0,1,2'b00,1,2'b01,8'h01,BE);
    add(0,0,0,0,0, 0,0,2'b00,1,2'b01,8'h01,BE);
    add(1,8,0,0,0, 0,1,2'b00,1,2'b01,8'h01,BE);
    add(0,0,0,0,1, 0,0,2'b01,0,2'b00,8'h00,B0);
    add(1,0,0,0,0, 1,0,2'b00,0,2'b00,8'h00,BA);  // draw game
    add(0,0,0,0,0, 0,0,2'b10,0,2'b00,8'h00,BA);
    add(0,0,1,1,0, 1,0,2'b00,0,2'b00,8'h00,C2);
    add(0,0,0,0,0, 0,0,2'b01,0,2'b00,8'h00,C2);
    add(1,2,0,0,0, 1,0,2'b00,0,2'b00,8'h00,C3);
    add(0,0,0,0,0, 0,0,2'b10,0,2'b00,8'h00,C3);
    add(0,0,1,4,0, 1,0,2'b00,0,2'b00,8'h00,C4);
    add(0,0,0,0,0, 0,0,2'b01,0,2'b00,8'h00,C4);
    add(1,3,0,0,0, 1,0,2'b00,0,2'b00,8'h00,C5);
    add(0,0,0,0,0, 0,0,2'b10,0,2'b00,8'h00,C5);
    add(0,0,1,5,0, 1,0,2'b00,0,2'b00,8'h00,C6);
    add(0,0,0,0,0, 0,0,2'b01,0,2'b00,8'h00,C6);
    add(1,7,0,0,0, 1,0,2'b00,0,2'b00,8'h00,C7);
    add(0,0,0,0,0, 0,0,2'b10,0,2'b00,8'h00,C7);
    add(0,0,1,6,0, 1,0,2'b00,0,2'b00,8'h00,C8);
    add(0,0,0,0,0, 0,0,2'b01,0,2'b00,8'h00,C8);
    add(1,8,0,0,0, 1,0,2'b00,0,2'b00,8'h00,C9);
    add(0,0,0,0,0, 0,0,2'b00,1,2'b00,8'h00,C9);
    add(0,0,0,0,1, 0,0,2'b01,0,2'b00,8'h00,B0);
    add(1,0,0,0,0, 1,0,2'b00,0,2'b00,8'h00,BA);  // held request
    add(1,0,0,0,0, 0,0,2'b10,0,2'b00,8'h00,BA);
    add(1,0,1,1,0, 1,0,2'b00,0,2'b00,8'h00,C2);
    add(1,3,0,0,0, 0,0,2'b01,0,2'b00,8'h00,C2);
    add(1,3,0,0,0, 0,0,2'b01,0,2'b00,8'h00,C2);
    add(0,0,0,0,0, 0,0,2'b01,0,2'b00,8'h00,C2);
    add(1,3,0,0,0, 1,0,2'b00,0,2'b00,8'h00,HC);
    add(0,0,1,5,0, 0,1,2'b10,0,2'b00,8'h00,HC);  // request during CHECK
    add(0,0,0,0,0, 0,0,2'b10,0,2'b00,8'h00,HC);
    add(0,0,1,5,0, 1,0,2'b00,0,2'b00,8'h00,HD);
    add(0,0,0,0,0, 0,0,2'b01,0,2'b00,8'h00,HD);

    reset_n = 1'b0;
    p1_req = 0; p1_idx = 0; p2_req = 0; p2_idx = 0; restart = 0;
    #25;
    check("reset_state", 64'(snap), 64'({1'b0, 1'b0, 2'b01, 1'b0, 2'b00, 8'h00, B0}));
    reset_n = 1'b1;
    @(posedge clk50M);
    #1;

    for (int k = 0; k < vq.size(); k++) begin
      cyc(vq[k].p1, vq[k].i1, vq[k].p2, vq[k].i2, vq[k].rs);
      check($sformatf("vec%0d", k), 64'(snap),
            64'({vq[k].ack, vq[k].nack, vq[k].turn, vq[k].go, vq[k].win, vq[k].wl, vq[k].brd}));
    end

    // Ninth move completes a row and a column at once: WIN, not DRAW.
    cyc(0,0,0,0,1);
    moves = '{1, 0, 3, 2, 5, 6, 7, 8, 4};
    for (int k = 0; k < 9; k++) begin
      if (k % 2 == 0) cyc(1, 4'(moves[k]), 0, 0, 0);
      else            cyc(0, 0, 1, 4'(moves[k]), 0);
      check($sformatf("win9_ack%0d", k), 64'({move_ack, move_nack}), 64'(2'b10));
      cyc(0,0,0,0,0);
      if (k < 8)
        check($sformatf("win9_turn%0d", k), 64'(turn), (k % 2 == 0) ? 64'(2'b10) : 64'(2'b01));
    end
    check("win9_result", 64'({turn, game_over, winner, win_line}),
          64'({2'b00, 1'b1, 2'b01, 8'h12}));
    check("win9_board", 64'(board), 64'(18'b10_01_10_01_01_01_10_01_10));

    // Asynchronous reset in the middle of CHECK, request held through release.
    cyc(0,0,0,0,1);
    cyc(1,0,0,0,0);
    check("pre_reset_ack", 64'({move_ack, board}), 64'({1'b1, BA}));
    #2 reset_n = 1'b0;
    #1;
    check("async_reset", 64'(snap), 64'({1'b0, 1'b0, 2'b01, 1'b0, 2'b00, 8'h00, B0}));
    @(posedge clk50M);
    #1;
    check("in_reset", 64'(snap), 64'({1'b0, 1'b0, 2'b01, 1'b0, 2'b00, 8'h00, B0}));
    reset_n = 1'b1;
    cyc(1,0,0,0,0);
    check("post_reset_new_req", 64'({move_ack, move_nack, board}), 64'({1'b1, 1'b0, BA}));
    cyc(0,0,0,0,0);
    check("post_reset_turn", 64'({move_ack, move_nack, turn}), 64'({1'b0, 1'b0, 2'b10}));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
